// File: rtl/cache_mshr_pkg.sv
// cache_mshr_pkg: shared types and width helper for the fill-queue MSHR.
package cache_mshr_pkg;
  // Entry index at the default 16-entry geometry; parameterised blocks size ids with ID_W.
  typedef logic [3:0] mshr_id_t;
  typedef enum logic {RPL_IDLE, RPL_ACTIVE} rpl_state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/cache_mshr_fill_fifo.sv
// cache_mshr_fill_fifo: circular FIFO of pending fill ids.
// Ports: clk, reset_n (async, active-low), push/din, pop/head, full, empty.
module cache_mshr_fill_fifo
  import cache_mshr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/cache_mshr_fq.sv
// cache_mshr_fq: MSHR with per-line miss chains, fill queue, payload store and occupancy tracking.
// Ports: fill_* (memory fill in), dequeue_* (replay out), allocate_* (bank slot request),
//        finalize_* (release / link of the last allocation), occupancy, almost_full.
// Optional macro CACHE_MSHR_PERF_EN adds perf_alloc_stalls, perf_fill_stalls, perf_peak_occ.
module cache_mshr_fq
  import cache_mshr_pkg::*;
#(
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int MSHR_SIZE       = 16,
  parameter int DATA_WIDTH      = 64,
  parameter int FILLQ_SIZE      = 4,
  parameter int ALM_FULL_MARGIN = 2,
  parameter int WRITEBACK       = 0,
  localparam int ID_W  = $clog2(MSHR_SIZE),
  localparam int CNT_W = cnt_width(MSHR_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fill_valid,
  output logic                       fill_ready,
  input  logic [ID_W-1:0]            fill_id,
  output logic [LINE_ADDR_WIDTH-1:0] fill_addr,
  output logic                       dequeue_valid,
  input  logic                       dequeue_ready,
  output logic [ID_W-1:0]            dequeue_id,
  output logic [LINE_ADDR_WIDTH-1:0] dequeue_addr,
  output logic                       dequeue_rw,
  output logic [DATA_WIDTH-1:0]      dequeue_data,
  input  logic                       allocate_valid,
  output logic                       allocate_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] allocate_addr,
  input  logic                       allocate_rw,
  input  logic [DATA_WIDTH-1:0]      allocate_data,
  output logic [ID_W-1:0]            allocate_id,
  output logic                       allocate_pending,
  output logic [ID_W-1:0]            allocate_previd,
  input  logic                       finalize_valid,
  input  logic                       finalize_is_release,
  input  logic                       finalize_is_pending,
  input  logic [ID_W-1:0]            finalize_id,
  input  logic [ID_W-1:0]            finalize_previd,
  output logic [CNT_W-1:0]           occupancy,
  output logic                       almost_full
`ifdef CACHE_MSHR_PERF_EN
  ,
  output logic [31:0]                perf_alloc_stalls,
  output logic [31:0]                perf_fill_stalls,
  output logic [CNT_W-1:0]           perf_peak_occ
`endif
);
  logic [MSHR_SIZE-1:0]       valid, next_bit, valid_n, next_n;
  logic [MSHR_SIZE-1:0]       alloc_mask, rel_mask, link_mask, match;
  logic [MSHR_SIZE-1:0]       rw_table;
  logic [LINE_ADDR_WIDTH-1:0] addr_table [MSHR_SIZE];
  logic [DATA_WIDTH-1:0]      data_table [MSHR_SIZE];
  logic [ID_W-1:0]            next_index [MSHR_SIZE];
  logic [ID_W-1:0]            free_id, fifo_head;
  logic [CNT_W-1:0]           occ_n;
  logic                       alloc_fire, deq_fire, link, race, pop, fifo_full, fifo_empty;
  rpl_state_t                 state;

  cache_mshr_fill_fifo #(.DEPTH(FILLQ_SIZE), .W(ID_W)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(fill_valid & ~fifo_full), .din(fill_id),
    .pop(pop), .head(fifo_head), .full(fifo_full), .empty(fifo_empty)
  );

  assign fill_ready   = ~fifo_full;
  assign fill_addr    = addr_table[fill_id];
  assign dequeue_addr = addr_table[dequeue_id];
  assign dequeue_rw   = rw_table[dequeue_id];
  assign dequeue_data = data_table[dequeue_id];

  always_comb begin
    alloc_fire = allocate_valid & allocate_ready;
    deq_fire   = dequeue_valid & dequeue_ready;
    link       = finalize_valid & finalize_is_pending;
    // A link onto the entry being replayed right now must be followed directly.
    race       = link & (finalize_previd == dequeue_id);
    alloc_mask = alloc_fire ? MSHR_SIZE'(1) << allocate_id : '0;
    rel_mask   = ((finalize_valid & finalize_is_release) ? MSHR_SIZE'(1) << finalize_id : '0) |
                 (deq_fire ? MSHR_SIZE'(1) << dequeue_id : '0);
    link_mask  = link ? MSHR_SIZE'(1) << finalize_previd : '0;
    valid_n    = (valid | alloc_mask) & ~rel_mask;
    // Clearing on allocate scrubs stale links left by spurious or late finalize links.
    next_n     = (next_bit & ~alloc_mask) | link_mask;
    pop        = ~fifo_empty & ((state == RPL_IDLE) | (deq_fire & ~next_bit[dequeue_id] & ~race));
    occ_n      = CNT_W'($countones(valid_n));
  end

  always_comb begin
    free_id         = '0;
    allocate_previd = '0;
    for (int i = 0; i < MSHR_SIZE; i++)
      match[i] = valid[i] & (addr_table[i] == allocate_addr) & ((WRITEBACK != 0) | ~rw_table[i]);
    for (int i = MSHR_SIZE - 1; i >= 0; i--) begin
      if (!valid_n[i]) free_id = ID_W'(i);
      if (match[i] && !next_bit[i]) allocate_previd = ID_W'(i);
    end
    allocate_pending = |match;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid          <= '0;
      next_bit       <= '0;
      allocate_ready <= 1'b0;
      allocate_id    <= '0;
      occupancy      <= '0;
      almost_full    <= 1'b0;
    end else begin
      valid          <= valid_n;
      next_bit       <= next_n;
      allocate_ready <= ~&valid_n;
      allocate_id    <= free_id;
      occupancy      <= occ_n;
      almost_full    <= (MSHR_SIZE - int'(occ_n)) <= ALM_FULL_MARGIN;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      addr_table[allocate_id] <= allocate_addr;
      rw_table[allocate_id]   <= allocate_rw;
      data_table[allocate_id] <= allocate_data;
    end
    if (link) next_index[finalize_previd] <= finalize_id;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RPL_IDLE;
      dequeue_valid <= 1'b0;
      dequeue_id    <= '0;
    end else if (state == RPL_IDLE) begin
      if (!fifo_empty) begin
        state         <= RPL_ACTIVE;
        dequeue_valid <= 1'b1;
        dequeue_id    <= fifo_head;
      end
    end else if (deq_fire) begin
      if (next_bit[dequeue_id]) dequeue_id <= next_index[dequeue_id];
      else if (race) dequeue_id <= finalize_id;
      else if (!fifo_empty) dequeue_id <= fifo_head;
      else begin
        state         <= RPL_IDLE;
        dequeue_valid <= 1'b0;
      end
    end
  end

`ifdef CACHE_MSHR_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_alloc_stalls <= '0;
      perf_fill_stalls  <= '0;
      perf_peak_occ     <= '0;
    end else begin
      if (allocate_valid && !allocate_ready && !(&perf_alloc_stalls)) perf_alloc_stalls <= perf_alloc_stalls + 1'b1;
      if (fill_valid && fifo_full && !(&perf_fill_stalls)) perf_fill_stalls <= perf_fill_stalls + 1'b1;
      if (occupancy > perf_peak_occ) perf_peak_occ <= occupancy;
    end
  end
`endif
endmodule

// File: tb/tb_cache_mshr_fq.sv
// tb_cache_mshr_fq: directed self-checking bench for cache_mshr_fq (4 entries, 2-deep fill queue, margin 1).
module tb_cache_mshr_fq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fill_valid = 1'b0, fill_ready;
  logic [1:0]  fill_id = '0;
  logic [25:0] fill_addr;
  logic        dequeue_valid, dequeue_ready = 1'b0, dequeue_rw;
  logic [1:0]  dequeue_id;
  logic [25:0] dequeue_addr;
  logic [63:0] dequeue_data;
  logic        allocate_valid = 1'b0, allocate_ready, allocate_rw = 1'b0, allocate_pending;
  logic [25:0] allocate_addr = '0;
  logic [63:0] allocate_data = '0;
  logic [1:0]  allocate_id, allocate_previd;
  logic        finalize_valid = 1'b0, finalize_is_release = 1'b0, finalize_is_pending = 1'b0;
  logic [1:0]  finalize_id = '0, finalize_previd = '0;
  logic [2:0]  occupancy;
  logic        almost_full;
`ifdef CACHE_MSHR_PERF_EN
  logic [31:0] perf_alloc_stalls, perf_fill_stalls;
  logic [2:0]  perf_peak_occ;
`endif
  int ncmp = 0;
  int nerr = 0;

  localparam logic [25:0] A = 26'h0123456, B0 = 26'h0000100, B1 = 26'h0000200, B2 = 26'h0000300,
                          B3 = 26'h0000400, X = 26'h0ABCDE0, Z = 26'h0055555, W = 26'h0077777,
                          V = 26'h0099999;

  cache_mshr_fq #(
    .LINE_ADDR_WIDTH(26), .MSHR_SIZE(4), .DATA_WIDTH(64), .FILLQ_SIZE(2),
    .ALM_FULL_MARGIN(1), .WRITEBACK(0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_id(fill_id), .fill_addr(fill_addr),
    .dequeue_valid(dequeue_valid), .dequeue_ready(dequeue_ready), .dequeue_id(dequeue_id),
    .dequeue_addr(dequeue_addr), .dequeue_rw(dequeue_rw), .dequeue_data(dequeue_data),
    .allocate_valid(allocate_valid), .allocate_ready(allocate_ready), .allocate_addr(allocate_addr),
    .allocate_rw(allocate_rw), .allocate_data(allocate_data), .allocate_id(allocate_id),
    .allocate_pending(allocate_pending), .allocate_previd(allocate_previd),
    .finalize_valid(finalize_valid), .finalize_is_release(finalize_is_release),
    .finalize_is_pending(finalize_is_pending), .finalize_id(finalize_id),
    .finalize_previd(finalize_previd), .occupancy(occupancy), .almost_full(almost_full)
`ifdef CACHE_MSHR_PERF_EN
    , .perf_alloc_stalls(perf_alloc_stalls), .perf_fill_stalls(perf_fill_stalls),
    .perf_peak_occ(perf_peak_occ)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One allocate cycle followed by its finalize cycle.
  task automatic alloc(input logic [25:0] a, input logic rw, input logic [63:0] d, input logic [1:0] id,
                       input logic pend, input logic [1:0] prev, input logic rel);
    allocate_valid = 1'b1;
    allocate_addr  = a;
    allocate_rw    = rw;
    allocate_data  = d;
    #1;
    chk("alloc_ready", allocate_ready, 1);
    chk("alloc_id", allocate_id, id);
    chk("alloc_pending", allocate_pending, pend);
    if (pend) chk("alloc_previd", allocate_previd, prev);
    tick();
    allocate_valid      = 1'b0;
    finalize_valid      = 1'b1;
    finalize_id         = id;
    finalize_previd     = prev;
    finalize_is_pending = pend;
    finalize_is_release = rel;
    tick();
    finalize_valid      = 1'b0;
    finalize_is_pending = 1'b0;
    finalize_is_release = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      fill_valid = 1'($urandom); fill_id = 2'($urandom); dequeue_ready = 1'($urandom);
      allocate_valid = 1'($urandom); allocate_addr = 26'($urandom); allocate_rw = 1'($urandom);
      finalize_valid = 1'($urandom); finalize_is_pending = 1'($urandom);
      finalize_is_release = 1'($urandom); finalize_id = 2'($urandom); finalize_previd = 2'($urandom);
      tick();
    end
    chk("rst_deq_valid", dequeue_valid, 0);
    chk("rst_alloc_ready", allocate_ready, 0);
    chk("rst_alloc_id", allocate_id, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_pending", allocate_pending, 0);
    fill_valid = 0; dequeue_ready = 0; allocate_valid = 0; allocate_rw = 0;
    finalize_valid = 0; finalize_is_pending = 0; finalize_is_release = 0;
    reset_n = 1'b1;
    #1;
    chk("rel_ready_low", allocate_ready, 0);
    tick();
    chk("rel_ready_high", allocate_ready, 1);
    chk("rel_alloc_id", allocate_id, 0);

    // Chain of three misses to line A, replayed from one fill
    alloc(A, 0, 64'hD0, 0, 0, 0, 0);
    alloc(A, 0, 64'hD1, 1, 1, 0, 0);
    alloc(A, 0, 64'hD2, 2, 1, 1, 0);
    chk("chain_occ3", occupancy, 3);
    chk("chain_af", almost_full, 1);
    chk("chain_next_id", allocate_id, 3);
    fill_valid = 1; fill_id = 0; dequeue_ready = 1;
    #1;
    chk("chain_fill_ready", fill_ready, 1);
    chk("chain_fill_addr", fill_addr, A);
    tick();
    fill_valid = 0;
    chk("chain_idle", dequeue_valid, 0);
    tick();
    chk("chain_dv0", dequeue_valid, 1);
    chk("chain_id0", dequeue_id, 0);
    chk("chain_data0", dequeue_data, 64'hD0);
    chk("chain_occ_a", occupancy, 3);
    tick();
    chk("chain_id1", dequeue_id, 1);
    chk("chain_occ_b", occupancy, 2);
    tick();
    chk("chain_id2", dequeue_id, 2);
    chk("chain_data2", dequeue_data, 64'hD2);
    chk("chain_addr2", dequeue_addr, A);
    chk("chain_occ_c", occupancy, 1);
    tick();
    chk("chain_done", dequeue_valid, 0);
    chk("chain_occ0", occupancy, 0);
    chk("chain_af0", almost_full, 0);
    dequeue_ready = 0;

    // Fill all four entries, then stall allocates while full
    alloc(B0, 0, 64'hB0, 0, 0, 0, 0);
    alloc(B1, 0, 64'hB1, 1, 0, 0, 0);
    alloc(B2, 0, 64'hB2, 2, 0, 0, 0);
    chk("fq_af3", almost_full, 1);
    alloc(B3, 0, 64'hB3, 3, 0, 0, 0);
    chk("full_ready", allocate_ready, 0);
    chk("full_occ", occupancy, 4);
    allocate_valid = 1;
    for (int i = 0; i < 5; i++) tick();
    allocate_valid = 0;
    chk("full_ready_held", allocate_ready, 0);
`ifdef CACHE_MSHR_PERF_EN
    chk("perf_alloc_stalls", perf_alloc_stalls, 5);
    chk("perf_peak_occ", perf_peak_occ, 4);
`endif

    // Four fills back-to-back against a 2-deep queue while replay is stalled
    fill_valid = 1; fill_id = 0; #1;
    chk("fq_ready_a", fill_ready, 1);
    tick();
    fill_id = 1; #1;
    chk("fq_ready_b", fill_ready, 1);
    tick();
    fill_id = 2; #1;
    chk("fq_ready_c", fill_ready, 1);
    chk("fq_dv", dequeue_valid, 1);
    chk("fq_id0", dequeue_id, 0);
    tick();
    fill_id = 3; #1;
    chk("fq_ready_full", fill_ready, 0);
    chk("fq_id0_stable", dequeue_id, 0);
    chk("fq_addr0_stable", dequeue_addr, B0);
    tick();
    dequeue_ready = 1; #1;
    chk("fq_ready_full2", fill_ready, 0);
    tick();
    chk("fq_ready_again", fill_ready, 1);
    chk("fq_id1", dequeue_id, 1);
    chk("fq_freed_ready", allocate_ready, 1);
    chk("fq_freed_id", allocate_id, 0);
    chk("fq_occ3", occupancy, 3);
    tick();
    fill_valid = 0;
    chk("fq_id2", dequeue_id, 2);
    chk("fq_data2", dequeue_data, 64'hB2);
    tick();
    chk("fq_id3", dequeue_id, 3);
    chk("fq_addr3", dequeue_addr, B3);
    tick();
    chk("fq_done", dequeue_valid, 0);
    chk("fq_occ0", occupancy, 0);
`ifdef CACHE_MSHR_PERF_EN
    chk("perf_fill_stalls", perf_fill_stalls, 2);
`endif
    dequeue_ready = 0;

    // Release on hit, then the tail-link race during replay
    alloc(X, 0, 64'hE0, 0, 0, 0, 0);
    alloc(X, 0, 64'hE1, 1, 1, 0, 0);
    alloc(Z, 0, 64'hE2, 2, 0, 0, 1);
    chk("rel_occ", occupancy, 2);
    chk("rel_reuse_id", allocate_id, 2);
    alloc(W, 0, 64'hE3, 2, 0, 0, 0);
    fill_valid = 1; fill_id = 0;
    tick();
    fill_valid = 0;
    allocate_valid = 1; allocate_addr = X; allocate_data = 64'hE4; allocate_rw = 0; #1;
    chk("race_alloc_id", allocate_id, 3);
    chk("race_pending", allocate_pending, 1);
    chk("race_previd", allocate_previd, 1);
    tick();
    allocate_valid = 0; dequeue_ready = 1; #1;
    chk("race_id0", dequeue_id, 0);
    tick();
    finalize_valid = 1; finalize_is_pending = 1; finalize_previd = 1; finalize_id = 3; #1;
    chk("race_id1", dequeue_id, 1);
    tick();
    finalize_valid = 0; finalize_is_pending = 0;
    chk("race_dv", dequeue_valid, 1);
    chk("race_id3", dequeue_id, 3);
    chk("race_data3", dequeue_data, 64'hE4);
    chk("race_rw3", dequeue_rw, 0);
    tick();
    chk("race_done", dequeue_valid, 0);
    chk("race_occ1", occupancy, 1);
    dequeue_ready = 0;
    allocate_addr = W; #1;
    chk("w_pending", allocate_pending, 1);
    chk("w_previd", allocate_previd, 2);

    // A write entry is not a pending target when writeback is off
    alloc(V, 1, 64'hF0, 0, 0, 0, 0);
    allocate_addr = V; #1;
    chk("wr_excluded", allocate_pending, 0);
    chk("wr_occ", occupancy, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
